// File: rtl/uart_act_core.sv
// Byte-stream activation core: groups bytes into sign-magnitude elements, applies
// pass/relu/abs/negate per byte, and buffers results in a FIFO drained by a guarded TX FSM.
module uart_act_core #(
  parameter int ELEM_BYTES = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic [1:0]                    mode,
  input  logic                          resync,
  input  logic                          tx_busy,
  output logic                          tx_en,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [COUNT_W-1:0]            elem_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEM_BYTES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {MODE_PASS, MODE_RELU, MODE_ABS, MODE_NEG} act_mode_e;
  typedef enum logic {ST_IDLE, ST_GUARD} tx_state_e;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               neg_q, neg_d;
  act_mode_e          cur_mode_q, cur_mode_d;
  logic [COUNT_W-1:0] elem_count_q, elem_count_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  tx_state_e          state_q, state_d;
  logic               tx_en_q;
  logic [7:0]         tx_data_q;
  logic [7:0]         mem [FIFO_DEPTH];

  logic               first, sign, push, pop;
  act_mode_e          eff_mode;
  logic [7:0]         act_byte;

  // Activation: the first byte carries the sign and selects the mode for the whole element.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    first    = resync || (idx_q == '0);
    eff_mode = first ? act_mode_e'(mode) : cur_mode_q;
    sign     = first ? rx_data[7] : neg_q;
    act_byte = rx_data;
    case (eff_mode)
      MODE_RELU: if (sign)  act_byte = 8'h00;
      MODE_ABS:  if (first) act_byte[7] = 1'b0;
      MODE_NEG:  if (first) act_byte[7] = ~rx_data[7];
      default:   ;
    endcase
  end

  // TX FSM output: pop only from IDLE; GUARD covers the UART's one-cycle busy lag.
  always_comb begin
    pop = (state_q == ST_IDLE) && (level_q != '0) && !tx_busy;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_GUARD;
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push         = rx_valid && ((level_q < LVL_FULL) || pop);
    idx_d        = idx_q;
    neg_d        = neg_q;
    cur_mode_d   = cur_mode_q;
    elem_count_d = elem_count_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d   = overflow_q | (rx_valid & ~push);
    level_d      = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: ;
    endcase

    if (resync) begin
      idx_d = '0;
      neg_d = 1'b0;
    end else if (rx_valid) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (idx_q == IDX_LAST) elem_count_d = elem_count_q + COUNT_W'(1);
    end
    // A byte arriving with resync still starts an element, so it latches mode and sign.
    if (rx_valid && first) begin
      neg_d      = rx_data[7];
      cur_mode_d = act_mode_e'(mode);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      idx_q        <= '0;
      neg_q        <= 1'b0;
      cur_mode_q   <= MODE_PASS;
      elem_count_q <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      idx_q        <= idx_d;
      neg_q        <= neg_d;
      cur_mode_q   <= cur_mode_d;
      elem_count_q <= elem_count_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      tx_en_q      <= pop;
      if (pop) tx_data_q <= mem[rd_ptr_q];
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers and level empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= act_byte;
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign elem_count = elem_count_q;

endmodule

// File: tb/tb_uart_act_core.sv
// Self-checking bench for uart_act_core: per-cycle reference model feeds a scoreboard
// queue; an independent monitor pops and compares every transmitted byte.
module tb_uart_act_core;

  localparam int EB = 2;
  localparam int D  = 4;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [1:0]  mode = 2'd0;
  logic        resync = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [$clog2(D):0] fifo_level;
  logic        overflow;
  logic [CW-1:0] elem_count;

  uart_act_core #(.ELEM_BYTES(EB), .FIFO_DEPTH(D), .COUNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data), .mode(mode),
    .resync(resync), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .fifo_level(fifo_level), .overflow(overflow), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Scoreboard and observed transmit log
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];

  // Reference model state
  int         lvl_m;
  bit         guard_m, ovf_m, sign_m;
  int         pos_m;
  logic [1:0] mode_m;
  logic [CW-1:0] ec_m;

  // Transmitter model
  int busy_cnt = 0;
  int frame    = 3;
  bit hold_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] activate(input logic [1:0] md, input bit s, input bit fst,
                                          input logic [7:0] b);
    logic [7:0] r;
    r = b;
    case (md)
      2'd1: r = s ? 8'h00 : b;                    // relu: whole element zero if negative
      2'd2: if (fst) r = b & 8'h7F;               // abs: clear sign bit
      2'd3: if (fst) r = b ^ 8'h80;               // negate: flip sign bit
      default: r = b;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    lvl_m = 0; guard_m = 0; ovf_m = 0; sign_m = 0; pos_m = 0; mode_m = 2'd0; ec_m = '0;
    exp_q.delete();
    busy_cnt = 0;
    tx_busy  = 1'b0;
  endtask

  task automatic model_step();
    bit pop_m, fst;
    logic [7:0] b;
    pop_m   = !guard_m && (lvl_m > 0) && !tx_busy;
    guard_m = pop_m;
    if (rx_valid) begin
      fst = (pos_m == 0) || resync;
      if (fst) begin
        mode_m = mode;
        sign_m = rx_data[7];
      end
      b = activate(mode_m, sign_m, fst, rx_data);
      if (lvl_m < D || pop_m) begin
        exp_q.push_back(b);
        lvl_m++;
      end else begin
        ovf_m = 1'b1;
      end
      if (resync) pos_m = 0;
      else if (pos_m == EB - 1) begin
        pos_m = 0;
        ec_m  = ec_m + 1'b1;
      end else pos_m++;
    end else if (resync) begin
      pos_m = 0;
    end
    if (pop_m) lvl_m--;
  endtask

  // One clock cycle: drive at negedge, model at posedge, check at next negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input logic [1:0] m, input bit r);
    rx_valid = v; rx_data = d; mode = m; resync = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (tx_en) busy_cnt = frame;
    tx_busy = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    check("fifo_level", fifo_level, lvl_m);
    check("overflow", overflow, ovf_m);
    check("elem_count", elem_count, ec_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, tx_en, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_elem_count"}, elem_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; rx_valid = 1'b0; resync = 1'b0; hold_busy = 1'b0;
    model_clear();
    tx_log.delete();
    tx_cyc.delete();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ev [4];
    ev = '{e0, e1, e2, e3};
    check({name, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++) check({name, "_byte"}, tx_log[i], ev[i]);
  endtask

  // Monitor: compares every transmitted byte against the scoreboard head.
  logic [7:0] last_data = 8'h00;
  bit         prev_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      last_data = 8'h00;
      prev_en   = 1'b0;
    end else if (tx_en) begin
      check("tx_en_spacing", prev_en, 0);
      check("tx_busy_honoured", tx_busy, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got=%0h expected=none (t=%0t)", tx_data, $time);
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
      last_data = tx_data;
      prev_en   = 1'b1;
    end else begin
      check("tx_data_hold", tx_data, last_data);
      prev_en = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // relu on positive and negative elements
    do_reset();
    frame = 3;
    cycle(1, 8'h3C, 2'd1, 0); cycle(1, 8'h00, 2'd1, 0);
    cycle(1, 8'hBC, 2'd1, 0); cycle(1, 8'h00, 2'd1, 0);
    idle(25);
    check_log("relu", 4, 8'h3C, 8'h00, 8'h00, 8'h00);
    check("relu_elem_count", elem_count, 2);

    // abs and negate, with a mode change after the first byte
    do_reset();
    cycle(1, 8'hC5, 2'd2, 0); cycle(1, 8'h12, 2'd1, 0);
    cycle(1, 8'h45, 2'd3, 0); cycle(1, 8'h12, 2'd2, 0);
    idle(25);
    check_log("abs_neg", 4, 8'h45, 8'h12, 8'hC5, 8'h12);

    // overflow with the transmitter held busy
    do_reset();
    hold_busy = 1'b1;
    idle(1);
    for (int i = 1; i <= 6; i++) cycle(1, 8'(i), 2'd0, 0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_elem_count", elem_count, 3);
    hold_busy = 1'b0;
    idle(30);
    check_log("ovf_drain", 4, 8'h01, 8'h02, 8'h03, 8'h04);
    check("ovf_sticky", overflow, 1);

    // resync after a lone first byte
    do_reset();
    cycle(1, 8'h80, 2'd1, 0);
    cycle(0, 8'h00, 2'd1, 1);
    cycle(1, 8'h3C, 2'd1, 0); cycle(1, 8'h01, 2'd1, 0);
    idle(25);
    check_log("resync", 3, 8'h00, 8'h3C, 8'h01, 8'h00);
    check("resync_elem_count", elem_count, 1);

    // latency and guard
    do_reset();
    cycle(1, 8'h5A, 2'd0, 0);
    check("lat_t1", tx_en, 0);
    idle(1);
    check("lat_t2", tx_en, 1);
    check("lat_t2_data", tx_data, 8'h5A);
    idle(1);
    check("lat_t3", tx_en, 0);
    idle(6);
    tx_log.delete(); tx_cyc.delete();
    cycle(1, 8'hA1, 2'd0, 0); cycle(1, 8'hA2, 2'd0, 0);
    idle(15);
    check_log("b2b", 2, 8'hA1, 8'hA2, 8'h00, 8'h00);
    if (tx_cyc.size() == 2) check("b2b_gap", tx_cyc[1] - tx_cyc[0], frame + 1);

    // reset mid-transmit with bytes still queued
    do_reset();
    hold_busy = 1'b1;
    idle(1);
    cycle(1, 8'h11, 2'd0, 0); cycle(1, 8'h22, 2'd0, 0); cycle(1, 8'h33, 2'd0, 0);
    hold_busy = 1'b0;
    idle(2);
    check("mid_tx_en", tx_en, 1);
    check("mid_level", fifo_level, 2);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    rx_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(20);
    check("no_tx_after_reset", tx_log.size(), 1);

    // randomized traffic against the reference model
    do_reset();
    frame = 2;
    for (int i = 0; i < 800; i++) begin
      bit v, r;
      if (i % 100 == 0) hold_busy = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 99) < 55);
      r = !v && ($urandom_range(0, 15) == 0);
      cycle(v, 8'($urandom), 2'($urandom), r);
    end
    hold_busy = 1'b0;
    idle(40);
    check("random_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
